// File: rtl/coord_norm_pkg.sv
// coord_norm_pkg: shared definitions for the coordinate normaliser.
//   - default per-point packed widths (input {flags,z,y,x}, output {flags,z,y,x})
//   - axis index constants
//   - popcount helper for clamp-flag vectors (up to POP_W flags)
package coord_norm_pkg;

    localparam int IN_COORD_W_DEF = 16;
    localparam int COORD_W_DEF    = 10;
    localparam int FLAG_W_DEF     = 2;

    // Per-point widths for the default build; the top derives its own
    // from its parameters.
    localparam int IN_PT_W  = 3*IN_COORD_W_DEF + FLAG_W_DEF;
    localparam int OUT_PT_W = 3*COORD_W_DEF + FLAG_W_DEF;

    localparam int AX_X = 0;
    localparam int AX_Y = 1;
    localparam int AX_Z = 2;

    localparam int POP_W = 64;

    function automatic logic [6:0] popcount(input logic [POP_W-1:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < POP_W; i++) n += 7'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/coord_axis_clamp.sv
// coord_axis_clamp: combinational arithmetic right shift plus clamp of one
// signed coordinate difference into [0, 2^COORD_W-1].
// Ports:
//   diff    in  DIFF_W   signed difference (two's complement)
//   shift   in  SHIFT_W  arithmetic right-shift amount
//   value   out COORD_W  clamped unsigned coordinate
//   lo_flag out 1        shifted value was negative
//   hi_flag out 1        shifted value exceeded 2^COORD_W-1
// DIFF_W must exceed COORD_W.
module coord_axis_clamp #(
    parameter int DIFF_W  = 17,
    parameter int SHIFT_W = 4,
    parameter int COORD_W = 10
) (
    input  logic [DIFF_W-1:0]  diff,
    input  logic [SHIFT_W-1:0] shift,
    output logic [COORD_W-1:0] value,
    output logic               lo_flag,
    output logic               hi_flag
);

    localparam logic signed [DIFF_W-1:0] MAX_V = {{(DIFF_W-COORD_W){1'b0}}, {COORD_W{1'b1}}};

    logic signed [DIFF_W-1:0] sh;

    assign sh      = $signed(diff) >>> shift;
    assign lo_flag = sh[DIFF_W-1];
    assign hi_flag = !lo_flag && (sh > MAX_V);
    assign value   = lo_flag ? '0 : (hi_flag ? '1 : sh[COORD_W-1:0]);

endmodule

// File: rtl/coord_normalizer_pipe.sv
// coord_normalizer_pipe: per-axis offset and power-of-two scale of a beat of
// NUM_POINTS signed XYZ points, clamped to unsigned COORD_W-bit coordinates,
// through a 2-stage valid/ready pipeline.
//   S1: diff = sext(coord) - sext(offset) per axis, shift and flags captured.
//   S2: shift + clamp (coord_axis_clamp), registered as out_data.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   in_data/in_valid/in_ready    input beat, point i = {flags,z,y,x} at i*IN point width
//   cfg_offset {z,y,x}, cfg_shift  runtime config, sampled at acceptance
//   out_data/out_valid/out_ready output beat, point i = {flags,z,y,x}
//   clr_stats               synchronous counter clear (wins over increment)
//   clamp_lo_cnt/clamp_hi_cnt    saturating clamp counters
// Optional: COORD_NORM_CLAMP_STATS_EN enables the clamp counters; without it
// the counters read 0 and clr_stats is ignored.
module coord_normalizer_pipe
    import coord_norm_pkg::*;
#(
    parameter int NUM_POINTS = 4,
    parameter int IN_COORD_W = 16,
    parameter int COORD_W    = 10,
    parameter int FLAG_W     = 2,
    parameter int SHIFT_W    = 4,
    parameter int CNT_W      = 16
) (
    input  logic                                      clk,
    input  logic                                      reset_n,
    input  logic [NUM_POINTS*(3*IN_COORD_W+FLAG_W)-1:0] in_data,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [3*IN_COORD_W-1:0]                   cfg_offset,
    input  logic [SHIFT_W-1:0]                        cfg_shift,
    output logic [NUM_POINTS*(3*COORD_W+FLAG_W)-1:0]  out_data,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    input  logic                                      clr_stats,
    output logic [CNT_W-1:0]                          clamp_lo_cnt,
    output logic [CNT_W-1:0]                          clamp_hi_cnt
);

    localparam int IPW = 3*IN_COORD_W + FLAG_W;
    localparam int OPW = 3*COORD_W + FLAG_W;
    localparam int DW  = IN_COORD_W + 1;   // difference never overflows
    localparam int NAX = AX_Z + 1;

    logic [2:1] vld_pipe;                  // [1] = S1 valid, [2] = S2 valid
    logic       s1_en, s2_en;

    logic [NUM_POINTS-1:0][NAX-1:0][DW-1:0]      diff_d, s1_diff;
    logic [NUM_POINTS-1:0][FLAG_W-1:0]           flags_d, s1_flags;
    logic [SHIFT_W-1:0]                          s1_shift;
    logic [NUM_POINTS-1:0][NAX-1:0][COORD_W-1:0] clamp_val;
    logic [NUM_POINTS-1:0][NAX-1:0]              lo_flag, hi_flag;
    logic [NUM_POINTS*OPW-1:0]                   out_d;

    assign s2_en     = !vld_pipe[2] || out_ready;
    assign s1_en     = !vld_pipe[1] || s2_en;
    assign in_ready  = s1_en;
    assign out_valid = vld_pipe[2];

    for (genvar p = 0; p < NUM_POINTS; p++) begin : g_pt
        assign flags_d[p] = in_data[p*IPW + NAX*IN_COORD_W +: FLAG_W];
        assign out_d[p*OPW + NAX*COORD_W +: FLAG_W] = s1_flags[p];

        for (genvar a = 0; a < NAX; a++) begin : g_ax
            logic [IN_COORD_W-1:0] crd, off;
            assign crd = in_data[p*IPW + a*IN_COORD_W +: IN_COORD_W];
            assign off = cfg_offset[a*IN_COORD_W +: IN_COORD_W];
            assign diff_d[p][a] = {crd[IN_COORD_W-1], crd} - {off[IN_COORD_W-1], off};

            coord_axis_clamp #(
                .DIFF_W  (DW),
                .SHIFT_W (SHIFT_W),
                .COORD_W (COORD_W)
            ) u_clamp (
                .diff    (s1_diff[p][a]),
                .shift   (s1_shift),
                .value   (clamp_val[p][a]),
                .lo_flag (lo_flag[p][a]),
                .hi_flag (hi_flag[p][a])
            );

            assign out_d[p*OPW + a*COORD_W +: COORD_W] = clamp_val[p][a];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            s1_diff  <= '0;
            s1_flags <= '0;
            s1_shift <= '0;
            out_data <= '0;
        end else begin
            if (s1_en) vld_pipe[1] <= in_valid;
            // Config is captured with the beat, so later changes never
            // reach a beat already in flight.
            if (s1_en && in_valid) begin
                s1_diff  <= diff_d;
                s1_flags <= flags_d;
                s1_shift <= cfg_shift;
            end
            if (s2_en) begin
                vld_pipe[2] <= vld_pipe[1];
                out_data    <= out_d;
            end
        end
    end

`ifdef COORD_NORM_CLAMP_STATS_EN
    localparam int SUM_W = ((CNT_W > 7) ? CNT_W : 7) + 1;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [6:0] n);
        logic [SUM_W-1:0] s;
        s = SUM_W'(c) + SUM_W'(n);
        return (s[SUM_W-1:CNT_W] != '0) ? '1 : s[CNT_W-1:0];
    endfunction

    logic [6:0] lo_n, hi_n;
    assign lo_n = popcount(POP_W'(lo_flag));
    assign hi_n = popcount(POP_W'(hi_flag));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clamp_lo_cnt <= '0;
            clamp_hi_cnt <= '0;
        end else if (clr_stats) begin
            clamp_lo_cnt <= '0;
            clamp_hi_cnt <= '0;
        end else if (s2_en && vld_pipe[1]) begin
            clamp_lo_cnt <= sat_add(clamp_lo_cnt, lo_n);
            clamp_hi_cnt <= sat_add(clamp_hi_cnt, hi_n);
        end
    end
`else
    logic unused_stats;
    assign unused_stats = ^{clr_stats, lo_flag, hi_flag};
    assign clamp_lo_cnt = '0;
    assign clamp_hi_cnt = '0;
`endif

endmodule

// File: tb/tb_coord_normalizer_pipe.sv
// Directed bench for coord_normalizer_pipe: a vector table for the datapath,
// plus hand-written sequences for streaming, stall, counter saturation,
// coincident clear and mid-operation reset. Counter expectations follow
// COORD_NORM_CLAMP_STATS_EN (0 when the feature is compiled out).
module tb_coord_normalizer_pipe;

    localparam int NP = 4, ICW = 16, CW = 10, FW = 2, SW = 4, CNTW = 4;
    localparam int IPW = 3*ICW + FW, OPW = 3*CW + FW;
    localparam int IW = NP*IPW, OW = NP*OPW;
`ifdef COORD_NORM_CLAMP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset_n;
    logic [IW-1:0]   in_data;
    logic            in_valid;
    logic            in_ready;
    logic [3*ICW-1:0] cfg_offset;
    logic [SW-1:0]   cfg_shift;
    logic [OW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready;
    logic            clr_stats;
    logic [CNTW-1:0] clamp_lo_cnt, clamp_hi_cnt;

    int checks = 0;
    int errors = 0;

    coord_normalizer_pipe #(
        .NUM_POINTS(NP), .IN_COORD_W(ICW), .COORD_W(CW),
        .FLAG_W(FW), .SHIFT_W(SW), .CNT_W(CNTW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .cfg_offset(cfg_offset), .cfg_shift(cfg_shift),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .clr_stats(clr_stats),
        .clamp_lo_cnt(clamp_lo_cnt), .clamp_hi_cnt(clamp_hi_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [IPW-1:0] pt_in(input int x, input int y, input int z, input logic [FW-1:0] f);
        return {f, ICW'(z), ICW'(y), ICW'(x)};
    endfunction

    function automatic logic [OPW-1:0] pt_out(input int x, input int y, input int z, input logic [FW-1:0] f);
        return {f, CW'(z), CW'(y), CW'(x)};
    endfunction

    function automatic logic [3*ICW-1:0] pack_off(input int ox, input int oy, input int oz);
        return {ICW'(oz), ICW'(oy), ICW'(ox)};
    endfunction

    function automatic logic [IW-1:0] rep_in(input logic [IPW-1:0] pt);
        logic [IW-1:0] r;
        for (int p = 0; p < NP; p++) r[p*IPW +: IPW] = pt;
        return r;
    endfunction

    function automatic logic [OW-1:0] rep_out(input logic [OPW-1:0] pt);
        logic [OW-1:0] r;
        for (int p = 0; p < NP; p++) r[p*OPW +: OPW] = pt;
        return r;
    endfunction

    // Reference clamp for offset 0 / shift 0 streams.
    function automatic int clampf(input int v);
        return (v < 0) ? 0 : ((v > 1023) ? 1023 : v);
    endfunction

    function automatic logic [IW-1:0] stream_in(input int b);
        logic [IW-1:0] r;
        for (int p = 0; p < NP; p++)
            r[p*IPW +: IPW] = pt_in(b*10 + p, 1000 + b + p, b*p*50 - 100, FW'(b + p));
        return r;
    endfunction

    function automatic logic [OW-1:0] stream_exp(input int b);
        logic [OW-1:0] r;
        for (int p = 0; p < NP; p++)
            r[p*OPW +: OPW] = pt_out(clampf(b*10 + p), clampf(1000 + b + p), clampf(b*p*50 - 100), FW'(b + p));
        return r;
    endfunction

    function automatic int exp_cnt(input int n);
        return STATS ? ((n > 15) ? 15 : n) : 0;
    endfunction

    // 8-beat stream with continuous in_valid; out_ready low for sl cycles from st.
    task automatic run_stream(input string tag, input int st, input int sl);
        int sent = 0, got = 0, first = -1, last = -1, cyc = 0;
        cfg_offset = '0;
        cfg_shift  = '0;
        while (got < 8 && cyc < 200) begin
            out_ready = !(cyc >= st && cyc < st + sl);
            in_valid  = (sent < 8);
            in_data   = stream_in(sent);
            #1;
            if (first >= 0) chk({tag, "_nobubble"}, OW'(out_valid), OW'(1));
            if (out_valid) begin
                if (first < 0) first = cyc;
                chk({tag, "_data"}, out_data, stream_exp(got));
                if (out_ready) begin
                    got++;
                    last = cyc;
                end
            end
            if (sl > 0 && cyc == st + sl - 1)
                chk({tag, "_stall_in_ready"}, OW'(in_ready), OW'(0));
            if (in_valid && in_ready) sent++;
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk({tag, "_count"}, OW'(got), OW'(8));
        chk({tag, "_span"}, OW'(last - first), OW'(7 + sl));
    endtask

    task automatic send_one(input logic [IW-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        tick();
        chk("one_valid", OW'(out_valid), OW'(1));
    endtask

    typedef struct {
        int ox, oy, oz, sh;
        int x, y, z;
        logic [FW-1:0] f;
        int ex, ey, ez;
        int lo, hi;        // clamps per point
    } vec_t;

    vec_t tbl[6];

    initial begin
        tbl[0] = '{0, 0, 0, 0,           500, 1023, 1024, 2'b01,  500, 1023, 1023, 0, 1};
        tbl[1] = '{-100, 0, 0, 2,        300, 8, -4, 2'b10,       100, 2, 0, 1, 0};
        tbl[2] = '{0, 0, 0, 0,           -200, 0, 1023, 2'b11,    0, 0, 1023, 1, 0};
        tbl[3] = '{-32768, 32767, 0, 6,  32767, -32768, 2047, 2'b10, 1023, 0, 31, 1, 0};
        tbl[4] = '{-32768, 0, 0, 15,     32767, 1000, -1, 2'b00,  1, 0, 0, 1, 0};
        tbl[5] = '{1, 1, 1, 0,           1024, 1025, 0, 2'b01,    1023, 1023, 0, 1, 1};

        reset_n    = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b1;
        clr_stats  = 1'b0;
        cfg_offset = '0;
        cfg_shift  = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", OW'(out_valid), OW'(0));
        chk("rst_out_data", out_data, '0);
        chk("rst_in_ready", OW'(in_ready), OW'(1));
        chk("rst_lo_cnt", OW'(clamp_lo_cnt), OW'(0));
        chk("rst_hi_cnt", OW'(clamp_hi_cnt), OW'(0));
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Table vectors: identical point on all lanes, config scrambled
        // right after acceptance to prove the in-flight beat keeps its own.
        for (int i = 0; i < 6; i++) begin
            cfg_offset = pack_off(tbl[i].ox, tbl[i].oy, tbl[i].oz);
            cfg_shift  = SW'(tbl[i].sh);
            clr_stats  = 1'b1;
            tick();
            clr_stats  = 1'b0;
            chk("vec_clr_lo", OW'(clamp_lo_cnt), OW'(0));
            in_valid = 1'b1;
            in_data  = rep_in(pt_in(tbl[i].x, tbl[i].y, tbl[i].z, tbl[i].f));
            #1;
            chk("vec_in_ready", OW'(in_ready), OW'(1));
            tick();
            in_valid   = 1'b0;
            cfg_offset = pack_off(777, -777, 5);
            cfg_shift  = SW'(3);
            chk("vec_lat1_valid", OW'(out_valid), OW'(0));
            tick();
            chk("vec_lat2_valid", OW'(out_valid), OW'(1));
            chk("vec_data", out_data, rep_out(pt_out(tbl[i].ex, tbl[i].ey, tbl[i].ez, tbl[i].f)));
            chk("vec_lo_cnt", OW'(clamp_lo_cnt), OW'(exp_cnt(NP*tbl[i].lo)));
            chk("vec_hi_cnt", OW'(clamp_hi_cnt), OW'(exp_cnt(NP*tbl[i].hi)));
            tick();
            chk("vec_drain", OW'(out_valid), OW'(0));
        end

        run_stream("stream", 0, 0);
        run_stream("stall", 4, 5);
        tick();

        // Counter saturation (CNT_W = 4): 12 clamps per beat.
        cfg_offset = '0;
        cfg_shift  = '0;
        clr_stats  = 1'b1;
        tick();
        clr_stats  = 1'b0;
        send_one(rep_in(pt_in(2000, 2000, 2000, 2'b00)));
        chk("sat_hi_12", OW'(clamp_hi_cnt), OW'(exp_cnt(12)));
        send_one(rep_in(pt_in(2000, 2000, 2000, 2'b00)));
        chk("sat_hi_15", OW'(clamp_hi_cnt), OW'(exp_cnt(15)));
        send_one(rep_in(pt_in(-5, -5, -5, 2'b00)));
        chk("sat_lo_12", OW'(clamp_lo_cnt), OW'(exp_cnt(12)));
        chk("sat_hi_hold", OW'(clamp_hi_cnt), OW'(exp_cnt(15)));
        send_one(rep_in(pt_in(-5, -5, -5, 2'b00)));
        chk("sat_lo_15", OW'(clamp_lo_cnt), OW'(exp_cnt(15)));

        // Clear coincident with a clamped beat entering S2: clear wins.
        in_valid = 1'b1;
        in_data  = rep_in(pt_in(-5, 2000, -5, 2'b01));
        tick();
        in_valid  = 1'b0;
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        chk("clr_coinc_valid", OW'(out_valid), OW'(1));
        chk("clr_coinc_lo", OW'(clamp_lo_cnt), OW'(0));
        chk("clr_coinc_hi", OW'(clamp_hi_cnt), OW'(0));
        tick();
        chk("clr_after_lo", OW'(clamp_lo_cnt), OW'(0));

        // Reset with both stages full.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = rep_in(pt_in(2000, 2000, 2000, 2'b11));
        tick();
        in_data   = rep_in(pt_in(-5, -5, -5, 2'b10));
        tick();
        in_valid  = 1'b0;
        chk("full_valid", OW'(out_valid), OW'(1));
        chk("full_in_ready", OW'(in_ready), OW'(0));
        chk("full_hi_cnt", OW'(clamp_hi_cnt), OW'(exp_cnt(12)));
        reset_n = 1'b0;
        #1;
        chk("midrst_valid", OW'(out_valid), OW'(0));
        chk("midrst_data", out_data, '0);
        chk("midrst_lo", OW'(clamp_lo_cnt), OW'(0));
        chk("midrst_hi", OW'(clamp_hi_cnt), OW'(0));
        chk("midrst_in_ready", OW'(in_ready), OW'(1));
        @(negedge clk);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("postrst_idle", OW'(out_valid), OW'(0));
        in_valid = 1'b1;
        in_data  = rep_in(pt_in(7, 8, 9, 2'b10));
        tick();
        in_valid = 1'b0;
        chk("postrst_lat1", OW'(out_valid), OW'(0));
        tick();
        chk("postrst_lat2", OW'(out_valid), OW'(1));
        chk("postrst_data", out_data, rep_out(pt_out(7, 8, 9, 2'b10)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
